fmc_master: RTL and testbench

FPGA-side initiator for the 16-bit asynchronous FMC/SRAM-style bus. It turns 32-bit command requests from internal logic into two back-to-back 16-bit FMC phases, driving ne1/noe/nwe/address/data with programmable address-setup, data-setup, strobe-pulse and bus-turnaround timing. It honours the responder's nwait stretch and is the bus-driving counterpart of fmc_slave, so it can talk to an fmc_slave in another FPGA or be used as a bench driver.

---
 rtl/fmc_master_if.sv | 27 ++
 rtl/fmc_master.sv | 186 ++++++++++++++++++
 tb/tb_fmc_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmc_master_if.sv
// fmc_master_if: command-side and FMC bus signals of the FMC initiator, with master/slave views
interface fmc_master_if;
  logic cmd_sel;
  logic cmd_rd_wr_n;
  logic [25:0] cmd_byte_addr;
  logic [31:0] cmd_wdata;
  logic cmd_ack;
  logic [31:0] cmd_rdata;
  logic cmd_err;
  logic cmd_busy;
  logic [24:0] fmc_a;
  logic [15:0] fmc_d_i;
  logic [15:0] fmc_d_o;
  logic fmc_d_high_z;
  logic fmc_ne1;
  logic fmc_noe;
  logic fmc_nwe;
  logic fmc_nwait;
  modport master (
    input cmd_sel, cmd_rd_wr_n, cmd_byte_addr, cmd_wdata, fmc_d_i, fmc_nwait,
    output cmd_ack, cmd_rdata, cmd_err, cmd_busy, fmc_a, fmc_d_o, fmc_d_high_z, fmc_ne1, fmc_noe, fmc_nwe
  );
  modport slave (
    output cmd_sel, cmd_rd_wr_n, cmd_byte_addr, cmd_wdata, fmc_d_i, fmc_nwait,
    input cmd_ack, cmd_rdata, cmd_err, cmd_busy, fmc_a, fmc_d_o, fmc_d_high_z, fmc_ne1, fmc_noe, fmc_nwe
  );
endinterface

// File: rtl/fmc_master.sv
// fmc_master: turns 32-bit commands into two 16-bit FMC phases with programmable setup/strobe/turnaround timing and nwait stretch
module fmc_master #(
  parameter int ADDR_SETUP_CLKS = 2,
  parameter int DATA_SETUP_CLKS = 4,
  parameter int STROBE_PULSE_CLKS = 2,
  parameter int BUS_TURN_CLKS = 2,
  parameter int NWAIT_EXTRA_CLKS = 4,
  parameter int NWAIT_TIMEOUT_CLKS = 1024
) (
  input logic i_sys_clk,
  input logic i_sys_rst_n,
  fmc_master_if.master bus
);
  localparam logic [15:0] AS_M1 = 16'(ADDR_SETUP_CLKS - 1);
  localparam logic [15:0] DS_M1 = 16'(DATA_SETUP_CLKS - 1);
  localparam logic [15:0] SP_M1 = 16'(STROBE_PULSE_CLKS - 1);
  localparam logic [15:0] BT_M1 = 16'(BUS_TURN_CLKS - 1);
  localparam logic [15:0] NX_M1 = 16'(NWAIT_EXTRA_CLKS - 1);
  localparam logic [15:0] TO_M1 = 16'(NWAIT_TIMEOUT_CLKS - 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, HOLD, PULSE, TURN} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic phase_q, phase_d, rd_q, rd_d, sticky_q, sticky_d;
  logic [24:0] base_q, base_d, a_q, a_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0] d_q, d_d;
  logic hz_q, hz_d, ne1_q, ne1_d, noe_q, noe_d, nwe_q, nwe_d;
  logic ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic nwait_meta_q, nwait_s_q;
  logic start, to_data, fin;
  logic unused;
  assign unused = bus.cmd_byte_addr[0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - 16'd1;
    phase_d = phase_q;
    rd_d = rd_q;
    base_d = base_q;
    wdata_d = wdata_q;
    sticky_d = sticky_q;
    a_d = a_q;
    d_d = d_q;
    hz_d = hz_q;
    ne1_d = ne1_q;
    noe_d = noe_q;
    nwe_d = nwe_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    busy_d = busy_q;
    rdata_d = rdata_q;
    start = 1'b0;
    to_data = 1'b0;
    fin = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_sel) begin
        rd_d = bus.cmd_rd_wr_n;
        base_d = bus.cmd_byte_addr[25:1];
        wdata_d = bus.cmd_wdata;
        phase_d = 1'b0;
        busy_d = 1'b1;
        start = 1'b1;
      end
      ADDR: to_data = cnt_q == 16'd0;
      DATA: if (cnt_q == 16'd0) begin
        if (!nwait_s_q) begin
          state_d = WAIT;
          cnt_d = 16'd0;
        end else fin = 1'b1;
      end
      WAIT: if (nwait_s_q) begin
        if (NWAIT_EXTRA_CLKS == 0) fin = 1'b1;
        else begin
          state_d = HOLD;
          cnt_d = NX_M1;
        end
      end else if (cnt_q == TO_M1) begin
        fin = 1'b1;
        sticky_d = 1'b1;
      end else cnt_d = cnt_q + 16'd1;
      HOLD: fin = cnt_q == 16'd0;
      PULSE: if (cnt_q == 16'd0) begin
        phase_d = 1'b1;
        start = 1'b1;
      end
      TURN: if (cnt_q == 16'd0) begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: ;
    endcase
    if (start) begin
      a_d = base_d + {24'd0, phase_d};
      ne1_d = 1'b0;
      noe_d = ~rd_d;
      nwe_d = 1'b1;
      hz_d = 1'b1;
      if (ADDR_SETUP_CLKS == 0) to_data = 1'b1;
      else begin
        state_d = ADDR;
        cnt_d = AS_M1;
      end
    end
    if (to_data) begin
      state_d = DATA;
      cnt_d = DS_M1;
      noe_d = ~rd_d;
      nwe_d = rd_d;
      hz_d = rd_d;
      d_d = phase_d ? wdata_d[31:16] : wdata_d[15:0];
    end
    if (fin) begin
      noe_d = 1'b1;
      nwe_d = 1'b1;
      hz_d = 1'b1;
      if (rd_q) rdata_d = phase_q ? {bus.fmc_d_i, rdata_q[15:0]} : {rdata_q[31:16], bus.fmc_d_i};
      if (!phase_q) begin
        state_d = PULSE;
        cnt_d = SP_M1;
      end else begin
        ne1_d = 1'b1;
        ack_d = 1'b1;
        err_d = sticky_d;
        sticky_d = 1'b0;
        if (BUS_TURN_CLKS == 0) begin
          state_d = IDLE;
          busy_d = 1'b0;
        end else begin
          state_d = TURN;
          cnt_d = BT_M1;
        end
      end
    end
  end
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n)
    if (!i_sys_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      phase_q <= 1'b0;
      rd_q <= 1'b0;
      sticky_q <= 1'b0;
      base_q <= '0;
      wdata_q <= '0;
      a_q <= '0;
      d_q <= '0;
      hz_q <= 1'b1;
      ne1_q <= 1'b1;
      noe_q <= 1'b1;
      nwe_q <= 1'b1;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      rdata_q <= '0;
      nwait_meta_q <= 1'b1;
      nwait_s_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      rd_q <= rd_d;
      sticky_q <= sticky_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      a_q <= a_d;
      d_q <= d_d;
      hz_q <= hz_d;
      ne1_q <= ne1_d;
      noe_q <= noe_d;
      nwe_q <= nwe_d;
      ack_q <= ack_d;
      err_q <= err_d;
      busy_q <= busy_d;
      rdata_q <= rdata_d;
      nwait_meta_q <= bus.fmc_nwait;
      nwait_s_q <= nwait_meta_q;
    end
  assign bus.cmd_ack = ack_q;
  assign bus.cmd_rdata = rdata_q;
  assign bus.cmd_err = err_q;
  assign bus.cmd_busy = busy_q;
  assign bus.fmc_a = a_q;
  assign bus.fmc_d_o = d_q;
  assign bus.fmc_d_high_z = hz_q;
  assign bus.fmc_ne1 = ne1_q;
  assign bus.fmc_noe = noe_q;
  assign bus.fmc_nwe = nwe_q;
endmodule

// File: tb/tb_fmc_master.sv
// tb_fmc_master: directed self-checking bench for fmc_master with a memory-backed FMC responder
module tb_fmc_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fmc_master_if bus();
  fmc_master dut (.i_sys_clk(clk), .i_sys_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic nwait_r = 1'b1;
  logic stretch = 1'b0;
  logic stuck_low = 1'b0;
  logic [15:0] mem [16] = '{4: 16'h1234, 5: 16'h5678, default: 16'h0};
  int wlen = 0, rlen = 0, ne1_rise = 0, ack_cnt = 0, hz_low = 0, wcnt = 0;
  logic [24:0] wa = '0, ra = '0;
  logic [15:0] wd = '0;
  logic ne1_prev = 1'b1, strobe_prev = 1'b0, strobe_now;
  int wlen_q[$], rlen_q[$];
  logic [24:0] wa_q[$], ra_q[$];
  logic [15:0] wd_q[$];
  int checks = 0, passed = 0;
  assign bus.fmc_nwait = stuck_low ? 1'b0 : nwait_r;
  assign bus.fmc_d_i = mem[bus.fmc_a[3:0]];
  always @(negedge clk) begin
    if (!bus.fmc_nwe) begin
      wlen++;
      wa = bus.fmc_a;
      wd = bus.fmc_d_o;
    end else if (wlen != 0) begin
      wlen_q.push_back(wlen);
      wa_q.push_back(wa);
      wd_q.push_back(wd);
      mem[wa[3:0]] = wd;
      wlen = 0;
    end
    if (!bus.fmc_noe) begin
      rlen++;
      ra = bus.fmc_a;
    end else if (rlen != 0) begin
      rlen_q.push_back(rlen);
      ra_q.push_back(ra);
      rlen = 0;
    end
    if (!bus.fmc_d_high_z) hz_low++;
    if (bus.fmc_ne1 && !ne1_prev) ne1_rise++;
    ne1_prev = bus.fmc_ne1;
    if (bus.cmd_ack) ack_cnt++;
    strobe_now = !bus.fmc_nwe || !bus.fmc_noe;
    if (stretch && strobe_now && !strobe_prev) begin
      wcnt = 20;
      nwait_r = 1'b0;
    end else if (wcnt != 0) begin
      wcnt--;
      if (wcnt == 0) nwait_r = 1'b1;
    end
    strobe_prev = strobe_now;
  end
  task automatic run_cmd(input logic rd, input logic [25:0] addr, input logic [31:0] wdat, input bit hold,
                         output bit ok, output logic [31:0] rdata, output logic err);
    bus.cmd_sel = 1'b1;
    bus.cmd_rd_wr_n = rd;
    bus.cmd_byte_addr = addr;
    bus.cmd_wdata = wdat;
    ok = 1'b0;
    rdata = 'x;
    err = 'x;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ack) begin
        ok = 1'b1;
        rdata = bus.cmd_rdata;
        err = bus.cmd_err;
        if (!hold) bus.cmd_sel = 1'b0;
      end
    end
    if (!ok) bus.cmd_sel = 1'b0;
    if (!hold) repeat (3) @(negedge clk);
  endtask
  task automatic test_reset();
    checks++;
    if ({bus.fmc_ne1, bus.fmc_noe, bus.fmc_nwe, bus.fmc_d_high_z} !== 4'hf)
      $display("FAIL reset_strobes got %b want 1111", {bus.fmc_ne1, bus.fmc_noe, bus.fmc_nwe, bus.fmc_d_high_z});
    else passed++;
    checks++;
    if ({bus.fmc_a, bus.fmc_d_o} !== 41'd0) $display("FAIL reset_bus got a=%h d=%h want 0", bus.fmc_a, bus.fmc_d_o);
    else passed++;
    checks++;
    if ({bus.cmd_ack, bus.cmd_err, bus.cmd_busy, bus.cmd_rdata} !== 35'd0)
      $display("FAIL reset_cmd got ack=%b err=%b busy=%b rdata=%h want 0", bus.cmd_ack, bus.cmd_err, bus.cmd_busy, bus.cmd_rdata);
    else passed++;
  endtask
  task automatic test_write();
    int b = wlen_q.size();
    int n = ne1_rise;
    int k = ack_cnt;
    bit ok;
    logic [31:0] rd;
    logic err;
    run_cmd(1'b0, 26'h0000004, 32'hcafebabe, 1'b0, ok, rd, err);
    checks++;
    if (ok !== 1'b1) $display("FAIL wr_ack got none want ack"); else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL wr_err got %b want 0", err); else passed++;
    checks++;
    if (wlen_q.size() - b !== 2) $display("FAIL wr_pulses got %0d want 2", wlen_q.size() - b); else passed++;
    checks++;
    if (wlen_q[b] !== 4 || wlen_q[b+1] !== 4) $display("FAIL wr_nwe_len got %0d,%0d want 4,4", wlen_q[b], wlen_q[b+1]);
    else passed++;
    checks++;
    if ({wa_q[b], wa_q[b+1]} !== {25'h2, 25'h3}) $display("FAIL wr_addr got %h,%h want 2,3", wa_q[b], wa_q[b+1]);
    else passed++;
    checks++;
    if ({wd_q[b+1], wd_q[b]} !== 32'hcafebabe) $display("FAIL wr_data got %h%h want cafebabe", wd_q[b+1], wd_q[b]);
    else passed++;
    checks++;
    if (ne1_rise - n !== 1) $display("FAIL wr_ne1_rises got %0d want 1", ne1_rise - n); else passed++;
    checks++;
    if (ack_cnt - k !== 1) $display("FAIL wr_ack_count got %0d want 1", ack_cnt - k); else passed++;
  endtask
  task automatic test_read();
    int b = rlen_q.size();
    int h = hz_low;
    bit ok;
    logic [31:0] rd;
    logic err;
    run_cmd(1'b1, 26'h0000008, 32'h0, 1'b0, ok, rd, err);
    checks++;
    if (ok !== 1'b1) $display("FAIL rd_ack got none want ack"); else passed++;
    checks++;
    if (rd !== 32'h56781234) $display("FAIL rd_data got %h want 56781234", rd); else passed++;
    checks++;
    if ({ra_q[b], ra_q[b+1]} !== {25'h4, 25'h5}) $display("FAIL rd_addr got %h,%h want 4,5", ra_q[b], ra_q[b+1]);
    else passed++;
    checks++;
    if (rlen_q[b] !== 6 || rlen_q[b+1] !== 6) $display("FAIL rd_noe_len got %0d,%0d want 6,6", rlen_q[b], rlen_q[b+1]);
    else passed++;
    checks++;
    if (hz_low - h !== 0) $display("FAIL rd_high_z got %0d driven cycles want 0", hz_low - h); else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL rd_err got %b want 0", err); else passed++;
  endtask
  task automatic test_nwait_stretch();
    int bw = wlen_q.size();
    int br = rlen_q.size();
    bit ok;
    logic [31:0] rd;
    logic err;
    stretch = 1'b1;
    run_cmd(1'b0, 26'h0000010, 32'hdeadbeef, 1'b0, ok, rd, err);
    checks++;
    if (ok !== 1'b1) $display("FAIL st_wr_ack got none want ack"); else passed++;
    checks++;
    if (wlen_q[bw] !== 27 || wlen_q[bw+1] !== 27) $display("FAIL st_nwe_len got %0d,%0d want 27,27", wlen_q[bw], wlen_q[bw+1]);
    else passed++;
    run_cmd(1'b1, 26'h0000010, 32'h0, 1'b0, ok, rd, err);
    checks++;
    if (ok !== 1'b1) $display("FAIL st_rd_ack got none want ack"); else passed++;
    checks++;
    if (rlen_q[br] !== 27 || rlen_q[br+1] !== 27) $display("FAIL st_noe_len got %0d,%0d want 27,27", rlen_q[br], rlen_q[br+1]);
    else passed++;
    checks++;
    if (rd !== 32'hdeadbeef) $display("FAIL st_rd_data got %h want deadbeef", rd); else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL st_err got %b want 0", err); else passed++;
    stretch = 1'b0;
    repeat (25) @(negedge clk);
  endtask
  task automatic test_timeout();
    int b = wlen_q.size();
    bit ok;
    logic [31:0] rd;
    logic err;
    stuck_low = 1'b1;
    run_cmd(1'b0, 26'h0000020, 32'h11112222, 1'b0, ok, rd, err);
    checks++;
    if (ok !== 1'b1) $display("FAIL to_ack got none want ack"); else passed++;
    checks++;
    if (err !== 1'b1) $display("FAIL to_err got %b want 1", err); else passed++;
    checks++;
    if (wlen_q[b] !== 1028 || wlen_q[b+1] !== 1028) $display("FAIL to_nwe_len got %0d,%0d want 1028,1028", wlen_q[b], wlen_q[b+1]);
    else passed++;
    checks++;
    if ({bus.fmc_ne1, bus.fmc_noe, bus.fmc_nwe, bus.fmc_d_high_z, bus.cmd_busy} !== 5'b11110)
      $display("FAIL to_idle got %b want 11110", {bus.fmc_ne1, bus.fmc_noe, bus.fmc_nwe, bus.fmc_d_high_z, bus.cmd_busy});
    else passed++;
    stuck_low = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    int b = wa_q.size();
    bit ok;
    logic [31:0] rd;
    logic err;
    run_cmd(1'b0, 26'h3fffffe, 32'h0badf00d, 1'b1, ok, rd, err);
    checks++;
    if (ok !== 1'b1 || err !== 1'b0) $display("FAIL b2b_ack1 got ok=%b err=%b want 1,0", ok, err); else passed++;
    @(negedge clk);
    checks++;
    if ({bus.cmd_busy, bus.fmc_ne1} !== 2'b11) $display("FAIL b2b_turn2 got %b want 11", {bus.cmd_busy, bus.fmc_ne1});
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.cmd_busy, bus.fmc_ne1} !== 2'b01) $display("FAIL b2b_idle got %b want 01", {bus.cmd_busy, bus.fmc_ne1});
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.cmd_busy, bus.fmc_ne1} !== 2'b10) $display("FAIL b2b_restart got %b want 10", {bus.cmd_busy, bus.fmc_ne1});
    else passed++;
    bus.cmd_sel = 1'b0;
    run_cmd(1'b0, 26'h3fffffe, 32'h0badf00d, 1'b0, ok, rd, err);
    checks++;
    if (ok !== 1'b1) $display("FAIL b2b_ack2 got none want ack"); else passed++;
    checks++;
    if (wa_q.size() - b !== 4) $display("FAIL b2b_pulses got %0d want 4", wa_q.size() - b); else passed++;
    checks++;
    if ({wa_q[b], wa_q[b+1]} !== {25'h1ffffff, 25'h0}) $display("FAIL b2b_wrap got %h,%h want 1ffffff,0", wa_q[b], wa_q[b+1]);
    else passed++;
  endtask
  task automatic test_async_reset();
    bit seen = 1'b0;
    int k;
    bit ok;
    logic [31:0] rd;
    logic err;
    bus.cmd_sel = 1'b1;
    bus.cmd_rd_wr_n = 1'b0;
    bus.cmd_byte_addr = 26'h0000018;
    bus.cmd_wdata = 32'h33334444;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (!bus.fmc_nwe) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL ar_data_phase got none want nwe low"); else passed++;
    k = ack_cnt;
    #2 rst_n = 1'b0;
    bus.cmd_sel = 1'b0;
    #1;
    checks++;
    if ({bus.fmc_ne1, bus.fmc_nwe, bus.fmc_d_high_z, bus.fmc_noe} !== 4'hf)
      $display("FAIL ar_strobes got %b want 1111", {bus.fmc_ne1, bus.fmc_nwe, bus.fmc_d_high_z, bus.fmc_noe});
    else passed++;
    checks++;
    if ({bus.cmd_busy, bus.cmd_rdata} !== 33'd0) $display("FAIL ar_cmd got busy=%b rdata=%h want 0", bus.cmd_busy, bus.cmd_rdata);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ack_cnt - k !== 0) $display("FAIL ar_no_ack got %0d acks want 0", ack_cnt - k); else passed++;
    run_cmd(1'b1, 26'h0000008, 32'h0, 1'b0, ok, rd, err);
    checks++;
    if (ok !== 1'b1 || rd !== 32'h56781234) $display("FAIL ar_read got ok=%b rdata=%h want 1,56781234", ok, rd);
    else passed++;
  endtask
  initial begin
    bus.cmd_sel = 1'b0;
    bus.cmd_rd_wr_n = 1'b0;
    bus.cmd_byte_addr = '0;
    bus.cmd_wdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_write();
    test_read();
    test_nwait_stretch();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
